black_box: RTL and testbench
============================

BLACK_BOX -- requirements
Module: black_box

Interface
REQ-001 Parameter CNT_W, default 8: width of the rising-edge counter, legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 g_out  output  1  combinational function of c_in, k_in and f_in.
REQ-005 c_in  input  1  data input, selected when k_in=0.
REQ-006 k_in  input  1  select input.
REQ-007 f_in  input  1  data input, selected when k_in=1.
REQ-008 g_q  output  1  g_out registered on clk.
REQ-009 rise_cnt  output  CNT_W  saturating count of g_q 0->1 transitions.
REQ-010 cov  output  8  input-combination coverage; bit index = {c_in,k_in,f_in}.
REQ-011 cov_full  output  1  high when all 8 cov bits are set.
REQ-012 Port declaration order SHALL be g_out, c_in, k_in, f_in, clk, reset, g_q, rise_cnt, cov, cov_full, so 4-port positional instances still bind the combinational core.

Function
REQ-013 g_out SHALL equal (k_in ? f_in : c_in), purely combinational with zero latency, independent of clk and reset.
REQ-014 The truth table indexed by {c_in,k_in,f_in} from 0 to 7 SHALL be 0,0,0,1,1,1,0,1, i.e. constant 8'hB8.
REQ-015 On each rising clk edge, g_q SHALL load the current g_out, giving 1-cycle latency.
REQ-016 On a rising edge with g_q=0 and g_out=1, rise_cnt SHALL increment by 1.
REQ-017 rise_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 On each rising edge, cov[{c_in,k_in,f_in}] SHALL be set to 1.
REQ-019 Set cov bits SHALL stay set until reset.
REQ-020 cov_full SHALL be the combinational AND of cov[7:0].
REQ-021 X or Z on the inputs is outside specified operation; no X-propagation guarantees are required.

Reset
REQ-022 Asserting reset SHALL immediately clear g_q, rise_cnt and cov, without waiting for a clock edge, so cov_full also goes to 0.
REQ-023 reset SHALL NOT affect g_out.
REQ-024 While reset is high, clock edges SHALL have no effect; reset dominates any simultaneous update.
REQ-025 On the first rising edge after reset is released, the same-cycle rules SHALL apply: g_q=0, so a high g_out counts as a rise.

Structure
REQ-026 Shared package black_box_pkg SHALL hold the CNT_W default and the TRUTH_TABLE constant 8'hB8.
REQ-027 One sub-module, black_box_core, SHALL hold the combinational g_out mux; the top SHALL hold the g_q register, the counter and the coverage register.

Verification
REQ-028 Exhaustive sweep: apply {c,k,f} = 000..111 for 10 time units each with clk idle -> g_out = 0,0,0,1,1,1,0,1.
REQ-029 Clocked sweep: after reset, apply all 8 combinations on 8 consecutive edges -> cov=8'hFF and cov_full=1 after the 8th edge.
REQ-030 Toggle test: alternate k=1,f=1 and k=1,f=0 over 10 edges -> rise_cnt=5, and g_q lags g_out by exactly one edge.
REQ-031 Saturation: with CNT_W=2, produce 5 rises -> rise_cnt stays at 3.
REQ-032 Async reset: assert reset mid-cycle with cov=8'hFF and rise_cnt=3 -> g_q, rise_cnt and cov are 0 before the next edge, while g_out still tracks the inputs.
REQ-033 Reset overlap: hold reset high across 3 edges with g_out=1 -> counter stays 0; the first edge after release gives rise_cnt=1.

Source files
------------

// File: rtl/black_box_pkg.sv
// Shared constants for the black_box slice: counter width default, the
// reference truth table of the select mux and the coverage index helper.
package black_box_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned COV_W         = 8;
    localparam int unsigned IDX_W         = 3;

    // Expected g_out for each {c_in,k_in,f_in}, bit index = that 3-bit value.
    localparam logic [COV_W-1:0] TRUTH_TABLE = 8'hB8;

    // Coverage bit index for one input combination.
    function automatic logic [IDX_W-1:0] cov_idx(input logic c, input logic k, input logic f);
        return {c, k, f};
    endfunction

endpackage

// File: rtl/black_box_core.sv
// Combinational core: two-way select, f_in when k_in is high, c_in otherwise.
// Ports:
//   g_out - selected data, zero latency
//   c_in  - data chosen when k_in = 0
//   k_in  - select
//   f_in  - data chosen when k_in = 1
module black_box_core (
    output logic g_out,
    input  logic c_in,
    input  logic k_in,
    input  logic f_in
);

    assign g_out = k_in ? f_in : c_in;

endmodule

// File: rtl/black_box.sv
// black_box: combinational select plus its registered copy, a saturating
// count of registered rising edges and a sticky input-combination coverage map.
// Ports:
//   g_out    - combinational select result (unaffected by clk/reset)
//   c_in     - data input when k_in = 0
//   k_in     - select input
//   f_in     - data input when k_in = 1
//   clk      - clock, rising edge
//   reset    - asynchronous, active-high reset
//   g_q      - g_out delayed by one clock
//   rise_cnt - saturating count of g_q 0->1 transitions
//   cov      - sticky coverage, bit {c_in,k_in,f_in} set when sampled
//   cov_full - all coverage bits set (combinational)
module black_box
    import black_box_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    output logic             g_out,
    input  logic             c_in,
    input  logic             k_in,
    input  logic             f_in,
    input  logic             clk,
    input  logic             reset,
    output logic             g_q,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [COV_W-1:0] cov,
    output logic             cov_full
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             rise_c;
    logic [COV_W-1:0] cov_nxt;

    // Keeps the combinational path in its own block so positional 4-port
    // instances of the top still see the mux on the first four ports.
    black_box_core u_core (
        .g_out (g_out),
        .c_in  (c_in),
        .k_in  (k_in),
        .f_in  (f_in)
    );

    // A rise is the register about to go 0 -> 1 on this edge.
    assign rise_c = ~g_q & g_out;

    // Mark the currently applied input combination.
    always_comb begin
        cov_nxt                      = cov;
        cov_nxt[cov_idx(c_in, k_in, f_in)] = 1'b1;
    end

    assign cov_full = &cov;

    // Registered copy, rise counter and coverage; reset wins over any edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q      <= 1'b0;
            rise_cnt <= '0;
            cov      <= '0;
        end else begin
            g_q <= g_out;
            if (rise_c && (rise_cnt != CNT_MAX)) begin
                rise_cnt <= rise_cnt + CNT_W'(1);
            end
            cov <= cov_nxt;
        end
    end

endmodule

// File: tb/tb_black_box.sv
// Directed self-checking bench for black_box; a second instance with a
// 2-bit counter shares the stimulus to exercise saturation.
module tb_black_box;

    logic       clk;
    logic       reset;
    logic       c_in;
    logic       k_in;
    logic       f_in;

    logic       g_out;
    logic       g_q;
    logic [7:0] rise_cnt;
    logic [7:0] cov;
    logic       cov_full;

    logic       s_g_out;
    logic       s_g_q;
    logic [1:0] s_rise_cnt;
    logic [7:0] s_cov;
    logic       s_cov_full;

    int n_checks;
    int n_pass;

    logic [7:0] tt;

    black_box dut (
        .g_out    (g_out),
        .c_in     (c_in),
        .k_in     (k_in),
        .f_in     (f_in),
        .clk      (clk),
        .reset    (reset),
        .g_q      (g_q),
        .rise_cnt (rise_cnt),
        .cov      (cov),
        .cov_full (cov_full)
    );

    black_box #(.CNT_W(2)) dut_sat (
        .g_out    (s_g_out),
        .c_in     (c_in),
        .k_in     (k_in),
        .f_in     (f_in),
        .clk      (clk),
        .reset    (reset),
        .g_q      (s_g_q),
        .rise_cnt (s_rise_cnt),
        .cov      (s_cov),
        .cov_full (s_cov_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full clock period; returns with clk low, 5 units after the edge.
    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic set_in(input logic [2:0] v);
        {c_in, k_in, f_in} = v;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        tt       = 8'hB8;
        clk      = 1'b0;
        reset    = 1'b0;
        set_in(3'b000);
        #1 reset = 1'b1;
        #1;

        // Reset state
        check("rst_g_q",      32'(g_q),      32'd0);
        check("rst_rise_cnt", 32'(rise_cnt), 32'd0);
        check("rst_cov",      32'(cov),      32'd0);
        check("rst_cov_full", 32'(cov_full), 32'd0);
        reset = 1'b0;

        // Exhaustive combinational sweep, clock idle
        for (int i = 0; i < 8; i++) begin
            set_in(3'(i));
            #10;
            check($sformatf("comb_g_out_%0d", i), 32'(g_out), 32'(tt[i]));
        end
        check("comb_s_g_out", 32'(s_g_out), 32'd1);
        check("idle_g_q",     32'(g_q),     32'd0);
        check("idle_cov",     32'(cov),     32'd0);

        // Clocked sweep: g sequence 0,0,0,1,1,1,0,1 -> rises at idx 3 and 7
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(3'(i));
            tick();
            check($sformatf("sweep_g_q_%0d", i), 32'(g_q), 32'(tt[i]));
            if (i == 6) begin
                check("sweep_cov_7", 32'(cov),      32'h7F);
                check("sweep_full_7", 32'(cov_full), 32'd0);
            end
        end
        check("sweep_cov",      32'(cov),        32'hFF);
        check("sweep_cov_full", 32'(cov_full),   32'd1);
        check("sweep_rise_cnt", 32'(rise_cnt),   32'd2);
        check("sweep_s_rise",   32'(s_rise_cnt), 32'd2);

        // Toggle test: k=1, f alternates 1,0 over 10 edges -> 5 rises
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            logic prev_g;
            prev_g = g_out;
            set_in({1'b0, 1'b1, (i % 2 == 0)});
            #1;
            check($sformatf("tog_lag_%0d", i), 32'(g_q), (i == 0) ? 32'd0 : 32'(prev_g));
            tick();
            check($sformatf("tog_g_q_%0d", i), 32'(g_q), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i == 4) check("tog_s_rise_3", 32'(s_rise_cnt), 32'd3);
            if (i == 6) check("tog_s_rise_4", 32'(s_rise_cnt), 32'd3);
        end
        check("tog_rise_cnt", 32'(rise_cnt),   32'd5);
        check("tog_s_sat",    32'(s_rise_cnt), 32'd3);
        check("tog_cov",      32'(cov),        32'h0C);

        // Build cov=FF, rise_cnt=3, then async reset mid-cycle
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(3'(i));
            tick();
        end
        set_in(3'b000);
        tick();
        set_in(3'b011);
        tick();
        check("pre_ar_rise", 32'(rise_cnt), 32'd3);
        check("pre_ar_cov",  32'(cov),      32'hFF);
        set_in(3'b100);
        #2 reset = 1'b1;
        #1;
        check("ar_g_q",      32'(g_q),      32'd0);
        check("ar_rise_cnt", 32'(rise_cnt), 32'd0);
        check("ar_cov",      32'(cov),      32'd0);
        check("ar_cov_full", 32'(cov_full), 32'd0);
        check("ar_g_out_1",  32'(g_out),    32'd1);
        set_in(3'b010);
        #1;
        check("ar_g_out_0",  32'(g_out),    32'd0);

        // Reset held across 3 edges with g_out=1, then first edge after release
        set_in(3'b011);
        tick();
        tick();
        tick();
        check("ov_rise_cnt", 32'(rise_cnt), 32'd0);
        check("ov_g_q",      32'(g_q),      32'd0);
        check("ov_cov",      32'(cov),      32'd0);
        reset = 1'b0;
        #1;
        tick();
        check("rel_rise_cnt", 32'(rise_cnt), 32'd1);
        check("rel_g_q",      32'(g_q),      32'd1);
        check("rel_cov",      32'(cov),      32'h08);
        check("rel_s_full",   32'(s_cov_full), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
